rv32i_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RV32I core. It consumes registered decode-stage fields (rs1/rs2 addresses, operand-use flags) and EX/MEM status. It produces per-stage stall and flush controls. It covers four cases: load-use interlock, multi-cycle data-memory wait with timeout, branch/jump redirect, and trap.

---
 rtl/rv32i_pkg.sv | 50 +++++
 rtl/rv32i_load_use_detect.sv | 34 +++
 rtl/rv32i_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32i_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I pipeline control slice:
//   - ctrl_state_e : hazard-controller FSM encodings (RUN/MEM_WAIT/FLUSH)
//   - OPC_*        : base opcode constants as produced by the decoder
//   - REG_X0       : index of the hard-wired zero register
//   - opc_uses_rs1/opc_uses_rs2 : derive operand-use flags from an opcode so
//     every consumer agrees on which instructions read rs1/rs2
// No ports (package).
// ----------------------------------------------------------------------------
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [4:0] REG_X0 = 5'd0;

  // rs1 is read by R, I, load, store, branch and jalr formats.
  function automatic logic opc_uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_R_TYPE, OPC_I_TYPE, OPC_LOAD,
      OPC_STORE, OPC_BRANCH, OPC_JALR: opc_uses_rs1 = 1'b1;
      default:                         opc_uses_rs1 = 1'b0;
    endcase
  endfunction

  // rs2 is read by R, store and branch formats.
  function automatic logic opc_uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_R_TYPE, OPC_STORE, OPC_BRANCH: opc_uses_rs2 = 1'b1;
      default:                           opc_uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_use_detect.sv
// ----------------------------------------------------------------------------
// rv32i_load_use_detect
// Purely combinational load-use comparator: flags when the instruction in
// decode reads a register that the load currently in EX will write.
// Ports:
//   i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2
//   i_ex_valid, i_ex_is_load, i_ex_rd_addr
//   o_load_use : hazard present this cycle
// ----------------------------------------------------------------------------
module rv32i_load_use_detect
  import rv32i_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd_addr,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit = i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr);

  // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
  assign o_load_use = i_id_valid & i_ex_valid & i_ex_is_load &
                      (i_ex_rd_addr != REG_X0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// rv32i_hazard_ctrl
// Central pipeline sequencer for the 5-stage RV32I core. Resolves load-use
// interlocks, multi-cycle data-memory waits (with timeout), branch/jump
// redirects and traps into per-stage stall/flush controls.
// Priority, highest first: trap > memory timeout > redirect > memory wait >
// load-use.
// Parameters: MEM_TIMEOUT (wait cycles before fault), TMO_W (counter width).
// Ports:
//   clk, rst_n (async, active-low)
//   i_id_*  : decode operand addresses/use flags, i_ex_* : EX load info
//   i_mem_req/i_mem_ack : data-memory handshake
//   i_ex_redirect, i_trap_req
//   o_stall_if/id/ex/mem, o_flush_id/ex : combinational stage controls
//   o_mem_fault : registered one-cycle pulse on memory timeout
//   o_ctrl_state: registered FSM state (debug)
// Optional: define HAZARD_CTRL_PERF_EN to add o_perf_stall_cnt and
//   o_perf_flush_cnt (32-bit saturating event counters).
// ----------------------------------------------------------------------------
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 200,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_ex_valid,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_mem_req,
  input  logic       i_mem_ack,
  input  logic       i_ex_redirect,
  input  logic       i_trap_req,
  output logic       o_stall_if,
  output logic       o_stall_id,
  output logic       o_stall_ex,
  output logic       o_stall_mem,
  output logic       o_flush_id,
  output logic       o_flush_ex,
  output logic       o_mem_fault,
  output logic [1:0] o_ctrl_state
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] o_perf_stall_cnt,
  output logic [31:0] o_perf_flush_cnt
`endif
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_cnt_nxt;
  logic [TMO_W-1:0] w_tmo_cnt_inc;
  logic             r_mem_fault;
  logic             w_mem_fault_nxt;
  logic             w_tmo_hit;
  logic             w_mem_wait;
  logic             w_load_use;

  rv32i_load_use_detect u_load_use (
    .i_id_valid    (i_id_valid),
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .i_ex_valid    (i_ex_valid),
    .i_ex_is_load  (i_ex_is_load),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .o_load_use    (w_load_use)
  );

  assign w_mem_wait = i_mem_req & ~i_mem_ack;
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(MEM_TIMEOUT));
  // Saturating increment: the counter parks at all-ones instead of wrapping.
  assign w_tmo_cnt_inc = (r_tmo_cnt == {TMO_W{1'b1}}) ? r_tmo_cnt
                                                      : (r_tmo_cnt + TMO_W'(1));

  // State, timeout counter and fault-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_tmo_cnt   <= {TMO_W{1'b0}};
      r_mem_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_mem_fault <= w_mem_fault_nxt;
    end
  end

  // Next-state, next-counter and fault decision.
  always_comb begin
    w_state_nxt     = r_state;
    w_tmo_cnt_nxt   = {TMO_W{1'b0}};
    w_mem_fault_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_trap_req || i_ex_redirect) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_mem_wait) begin
          w_state_nxt   = ST_MEM_WAIT;
          w_tmo_cnt_nxt = TMO_W'(1);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // Redirect is deliberately not examined: EX is frozen and will
        // present it again once the wait ends.
        if (i_trap_req) begin
          w_state_nxt = ST_FLUSH;
        end else if (i_mem_ack) begin
          w_state_nxt = ST_RUN;
        end else if (w_tmo_hit) begin
          w_state_nxt     = ST_FLUSH;
          w_mem_fault_nxt = 1'b1;
        end else begin
          w_state_nxt   = ST_MEM_WAIT;
          w_tmo_cnt_nxt = w_tmo_cnt_inc;
        end
      end
      ST_FLUSH: begin
        if (i_trap_req) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Stage stall/flush controls, decoded from the current state and inputs.
  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    if (!rst_n) begin
      // Keep the pipeline filled with bubbles while reset is held.
      o_flush_id = 1'b1;
      o_flush_ex = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_trap_req || i_ex_redirect) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
          end else if (w_mem_wait) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
          end else if (w_load_use) begin
            // Hold IF/ID and inject one bubble into EX.
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_ex = 1'b1;
          end else begin
            o_stall_if = 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          if (i_trap_req || (!i_mem_ack && w_tmo_hit)) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
          end else if (!i_mem_ack) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
          end else begin
            o_stall_if = 1'b0;
          end
        end
        ST_FLUSH: begin
          o_flush_id = 1'b1;
          o_flush_ex = 1'b1;
        end
        default: begin
          o_flush_id = 1'b1;
          o_flush_ex = 1'b1;
        end
      endcase
    end
  end

  assign o_mem_fault  = r_mem_fault;
  assign o_ctrl_state = r_state;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= 32'd0;
      r_perf_flush_cnt <= 32'd0;
    end else begin
      if (o_stall_if && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
      if (o_flush_ex && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
    end
  end

  assign o_perf_stall_cnt = r_perf_stall_cnt;
  assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rv32i_hazard_ctrl
// Directed self-checking bench for rv32i_hazard_ctrl (MEM_TIMEOUT=4).
// Observed vector layout: {ctrl_state[1:0], mem_fault, stall_if, stall_id,
// stall_ex, stall_mem, flush_id, flush_ex}.
// Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
// ----------------------------------------------------------------------------
module tb_rv32i_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd_addr;
  logic       mem_req;
  logic       mem_ack;
  logic       ex_redirect;
  logic       trap_req;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex;
  logic       mem_fault;
  logic [1:0] ctrl_state;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  logic [8:0] obs;
  int checks;
  int errors;

  // Expected observation vectors
  localparam logic [8:0] E_IDLE     = 9'b00_0_0000_00;
  localparam logic [8:0] E_RST      = 9'b00_0_0000_11;
  localparam logic [8:0] E_LU       = 9'b00_0_1100_01;
  localparam logic [8:0] E_RUN_STL  = 9'b00_0_1111_00;
  localparam logic [8:0] E_MW_STL   = 9'b01_0_1111_00;
  localparam logic [8:0] E_MW_REL   = 9'b01_0_0000_00;
  localparam logic [8:0] E_MW_FLUSH = 9'b01_0_0000_11;
  localparam logic [8:0] E_RUN_FL   = 9'b00_0_0000_11;
  localparam logic [8:0] E_FLUSH    = 9'b10_0_0000_11;
  localparam logic [8:0] E_FLUSH_F  = 9'b10_1_0000_11;

  assign obs = {ctrl_state, mem_fault, stall_if, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex};

  rv32i_hazard_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs1_addr (id_rs1_addr),
    .i_id_rs2_addr (id_rs2_addr),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_valid    (ex_valid),
    .i_ex_is_load  (ex_is_load),
    .i_ex_rd_addr  (ex_rd_addr),
    .i_mem_req     (mem_req),
    .i_mem_ack     (mem_ack),
    .i_ex_redirect (ex_redirect),
    .i_trap_req    (trap_req),
    .o_stall_if    (stall_if),
    .o_stall_id    (stall_id),
    .o_stall_ex    (stall_ex),
    .o_stall_mem   (stall_mem),
    .o_flush_id    (flush_id),
    .o_flush_ex    (flush_ex),
    .o_mem_fault   (mem_fault),
    .o_ctrl_state  (ctrl_state)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .o_perf_stall_cnt (perf_stall_cnt),
    .o_perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd_addr = 5'd0;
    mem_req = 1'b0; mem_ack = 1'b0; ex_redirect = 1'b0; trap_req = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
    id_valid = 1'b1; id_rs1_addr = rs1; id_uses_rs1 = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if (obs !== E_RST) begin errors++; $display("FAIL reset_outputs got %b exp %b", obs, E_RST); end
`ifdef HAZARD_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL post_reset_idle got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    set_load_use(5'd5, 5'd5);
    #4;
    checks++;
    if (obs !== E_LU) begin errors++; $display("FAIL lu_rs1_bubble got %b exp %b", obs, E_LU); end
    tick();
    // Load has advanced; EX now holds the bubble.
    ex_valid = 1'b0; ex_is_load = 1'b0;
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL lu_clears got %b exp %b", obs, E_IDLE); end
    tick();
    set_load_use(5'd0, 5'd0);
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL lu_rd_x0 got %b exp %b", obs, E_IDLE); end
    tick();
    set_load_use(5'd5, 5'd6);
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL lu_no_match got %b exp %b", obs, E_IDLE); end
    tick();
    clear_inputs();
    id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd7;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd7;
    #4;
    checks++;
    if (obs !== E_LU) begin errors++; $display("FAIL lu_rs2_bubble got %b exp %b", obs, E_LU); end
    tick();
    id_valid = 1'b0;
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL lu_id_invalid got %b exp %b", obs, E_IDLE); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; mem_ack = 1'b1;
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL mem_same_cycle_ack got %b exp %b", obs, E_IDLE); end
    tick();
    mem_ack = 1'b0;
    #4;
    checks++;
    if (obs !== E_RUN_STL) begin errors++; $display("FAIL mw_cycle0 got %b exp %b", obs, E_RUN_STL); end
    tick();
    for (int i = 1; i <= 2; i++) begin
      #4;
      checks++;
      if (obs !== E_MW_STL) begin errors++; $display("FAIL mw_cycle%0d got %b exp %b", i, obs, E_MW_STL); end
      tick();
    end
    mem_ack = 1'b1;
    #4;
    checks++;
    if (obs !== E_MW_REL) begin errors++; $display("FAIL mw_ack_release got %b exp %b", obs, E_MW_REL); end
    tick();
    clear_inputs();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL mw_back_to_run got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  task automatic test_timeout();
    mem_req = 1'b1;
    #4;
    checks++;
    if (obs !== E_RUN_STL) begin errors++; $display("FAIL tmo_enter got %b exp %b", obs, E_RUN_STL); end
    tick();
    for (int i = 1; i <= 3; i++) begin
      #4;
      checks++;
      if (obs !== E_MW_STL) begin errors++; $display("FAIL tmo_wait%0d got %b exp %b", i, obs, E_MW_STL); end
      tick();
    end
    #4;
    checks++;
    if (obs !== E_MW_FLUSH) begin errors++; $display("FAIL tmo_hit got %b exp %b", obs, E_MW_FLUSH); end
    tick();
    mem_req = 1'b0;
    #4;
    checks++;
    if (obs !== E_FLUSH_F) begin errors++; $display("FAIL tmo_fault_pulse got %b exp %b", obs, E_FLUSH_F); end
    tick();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL tmo_fault_clears got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  task automatic test_redirect();
    set_load_use(5'd5, 5'd5);
    ex_redirect = 1'b1;
    #4;
    checks++;
    if (obs !== E_RUN_FL) begin errors++; $display("FAIL redir_over_lu got %b exp %b", obs, E_RUN_FL); end
    tick();
    clear_inputs();
    #4;
    checks++;
    if (obs !== E_FLUSH) begin errors++; $display("FAIL redir_flush_state got %b exp %b", obs, E_FLUSH); end
    tick();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL redir_back_run got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  task automatic test_trap_mem_wait();
    mem_req = 1'b1;
    tick();
    // Redirect in MEM_WAIT must be ignored.
    ex_redirect = 1'b1;
    #4;
    checks++;
    if (obs !== E_MW_STL) begin errors++; $display("FAIL mw_redirect_ignored got %b exp %b", obs, E_MW_STL); end
    tick();
    ex_redirect = 1'b0;
    trap_req = 1'b1;
    #4;
    checks++;
    if (obs !== E_MW_FLUSH) begin errors++; $display("FAIL trap_in_mw got %b exp %b", obs, E_MW_FLUSH); end
    tick();
    // Second trap while flushing keeps FLUSH one more cycle.
    mem_req = 1'b0;
    #4;
    checks++;
    if (obs !== E_FLUSH) begin errors++; $display("FAIL trap_flush1 got %b exp %b", obs, E_FLUSH); end
    tick();
    trap_req = 1'b0;
    #4;
    checks++;
    if (obs !== E_FLUSH) begin errors++; $display("FAIL trap_flush_extend got %b exp %b", obs, E_FLUSH); end
    tick();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL trap_back_run got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  task automatic test_async_reset();
    mem_req = 1'b1;
    tick();
    tick();
    #4;
    checks++;
    if (obs !== E_MW_STL) begin errors++; $display("FAIL arst_pre_wait got %b exp %b", obs, E_MW_STL); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_RST) begin errors++; $display("FAIL arst_immediate got %b exp %b", obs, E_RST); end
`ifdef HAZARD_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
      errors++; $display("FAIL arst_perf got %0d/%0d exp 0/0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #4;
    checks++;
    if (obs !== E_IDLE) begin errors++; $display("FAIL arst_release got %b exp %b", obs, E_IDLE); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_redirect();
    test_trap_mem_wait();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
